// File: rtl/rand_stall_pkg.sv
// Shared types, LFSR step and per-channel seed derivation for the stall gate.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rand_stall_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_FIXED   = 2'd1,
        MODE_UNIFORM = 2'd2,
        MODE_BURST   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OPEN = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // One step of a right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

    // Channel seed; an all-zero LFSR would lock up, so it is replaced by 1.
    function automatic logic [31:0] chan_seed(input logic [31:0] base, input int unsigned chan);
        logic [31:0] s;
        s = base ^ chan;
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/rand_stall_chan.sv
// One gated channel: draws a delay per transaction, holds the handshake closed, counts stalls.
// Latency: zero when open (valid/ready pass combinationally); closed for N cycles after each draw.
// Backpressure: downstream ready passes straight through while open; OPEN persists until the handshake(s).
module rand_stall_chan
    import rand_stall_pkg::*;
#(
    parameter int unsigned CntWidth  = 8,
    parameter int unsigned StatWidth = 16,
    parameter int unsigned BurstLen  = 4,
    parameter logic [31:0] Seed      = 32'hACE1_2468
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           mode_i,
    input  logic [CntWidth-1:0]  min_i,
    input  logic [CntWidth-1:0]  max_i,
    input  logic                 clear_i,
    input  logic                 valid_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic [StatWidth-1:0] stall_cnt_o
);

    localparam int unsigned BW = (BurstLen < 2) ? 1 : $clog2(BurstLen + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BurstLen);

    state_e                state_q, state_d;
    mode_e                 bmode_q, bmode_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic [StatWidth-1:0]  stall_q, stall_d;

    logic [CntWidth-1:0]   lo, hi, delay;
    logic [CntWidth:0]     span;
    logic [31:0]           rem;
    logic                  open;

    // Delay candidate from the current LFSR value; span is one bit wider so a full-range window cannot wrap.
    always_comb begin
        lo   = (min_i <= max_i) ? min_i : max_i;
        hi   = (min_i <= max_i) ? max_i : min_i;
        span = {1'b0, hi} - {1'b0, lo} + {{CntWidth{1'b0}}, 1'b1};
        rem  = lfsr_q % 32'(span);
        case (mode_e'(mode_i))
            MODE_BYPASS: delay = '0;
            MODE_FIXED:  delay = min_i;
            default:     delay = lo + CntWidth'(rem);
        endcase
    end

    // Next-state logic and gate opening; mode is latched at the draw and only the latched copy governs OPEN.
    always_comb begin
        state_d = state_q;
        bmode_d = bmode_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        lfsr_d  = lfsr_q;
        open    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i && rst_ni) begin
                    lfsr_d  = lfsr_next(lfsr_q);
                    bmode_d = mode_e'(mode_i);
                    if (delay == '0) begin
                        open = 1'b1;
                        if (ready_i) begin
                            if ((mode_e'(mode_i) == MODE_BURST) && (BurstLen > 1)) begin
                                state_d = ST_OPEN;
                                burst_d = BW'(1);
                            end
                        end else begin
                            state_d = ST_OPEN;
                            burst_d = '0;
                        end
                    end else if (delay == CntWidth'(1)) begin
                        state_d = ST_OPEN;
                        burst_d = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = delay - CntWidth'(1);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CntWidth'(1);
                if (cnt_q == CntWidth'(1)) begin
                    state_d = ST_OPEN;
                    burst_d = '0;
                end
            end
            ST_OPEN: begin
                open = 1'b1;
                if (valid_i && ready_i) begin
                    if ((bmode_q != MODE_BURST) || ((burst_q + BW'(1)) >= BURST_LAST)) begin
                        state_d = ST_IDLE;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + BW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating stall statistic; clear takes priority over a same-cycle increment.
    always_comb begin
        stall_d = stall_q;
        if (clear_i) begin
            stall_d = '0;
        end else if (valid_i && !open && (stall_q != '1)) begin
            stall_d = stall_q + StatWidth'(1);
        end
    end

    // State registers; reset aborts any wait or window and reseeds the LFSR.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            bmode_q <= MODE_BYPASS;
            cnt_q   <= '0;
            burst_q <= '0;
            lfsr_q  <= Seed;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            bmode_q <= bmode_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            lfsr_q  <= lfsr_d;
            stall_q <= stall_d;
        end
    end

    assign valid_o     = valid_i & open;
    assign ready_o     = ready_i & open;
    assign busy_o      = (state_q != ST_IDLE);
    assign stall_cnt_o = stall_q;

endmodule

// File: rtl/rand_stall_gate.sv
// Multi-channel handshake throttle; one independent rand_stall_chan per channel, shared config.
// Latency: zero added when a channel is open; N closed cycles after each new transaction.
// Backpressure: per-channel ready passes through while open; a stalled window stays open until handshakes complete.
module rand_stall_gate
    import rand_stall_pkg::*;
#(
    parameter int unsigned NumChannels = 1,
    parameter int unsigned CntWidth    = 8,
    parameter int unsigned StatWidth   = 16,
    parameter int unsigned BurstLen    = 4,
    parameter logic [31:0] LfsrSeed    = 32'hACE1_2468
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [1:0]                       mode_i,
    input  logic [CntWidth-1:0]              min_i,
    input  logic [CntWidth-1:0]              max_i,
    input  logic                             clear_i,
    input  logic [NumChannels-1:0]           valid_i,
    output logic [NumChannels-1:0]           ready_o,
    output logic [NumChannels-1:0]           valid_o,
    input  logic [NumChannels-1:0]           ready_i,
    output logic [NumChannels-1:0]           busy_o,
    output logic [NumChannels*StatWidth-1:0] stall_cnt_o
);

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        rand_stall_chan #(
            .CntWidth  (CntWidth),
            .StatWidth (StatWidth),
            .BurstLen  (BurstLen),
            .Seed      (chan_seed(LfsrSeed, c))
        ) u_chan (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .mode_i      (mode_i),
            .min_i       (min_i),
            .max_i       (max_i),
            .clear_i     (clear_i),
            .valid_i     (valid_i[c]),
            .ready_i     (ready_i[c]),
            .valid_o     (valid_o[c]),
            .ready_o     (ready_o[c]),
            .busy_o      (busy_o[c]),
            .stall_cnt_o (stall_cnt_o[c*StatWidth +: StatWidth])
        );
    end

endmodule

// File: tb/tb_rand_stall_gate.sv
// Self-checking bench for rand_stall_gate with a transaction-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rand_stall_gate;

    localparam int NCH = 2;
    localparam int SW  = 4;
    localparam int BL  = 4;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic [1:0]        mode;
    logic [7:0]        min_v, max_v;
    logic [NCH-1:0]    valid_in, ready_in, valid_out, ready_out, busy;
    logic [NCH*SW-1:0] stall;

    int checks;
    int errors;

    // Reference model: per channel, "remaining closed cycles" and "handshakes left in the window".
    bit          m_active[NCH];
    bit          m_open[NCH];
    int          m_wait[NCH];
    int          m_hs[NCH];
    int          m_stall[NCH];
    logic [31:0] m_lfsr[NCH];
    int          m_draws[$];

    logic [NCH-1:0]    exp_v, exp_r, exp_b, obs_v, obs_r, obs_b;
    logic [NCH*SW-1:0] exp_s, obs_s;
    int                obs_d[$];
    int                run_a[$];

    rand_stall_gate #(
        .NumChannels (NCH),
        .CntWidth    (8),
        .StatWidth   (SW),
        .BurstLen    (BL),
        .LfsrSeed    (SEED)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mode_i      (mode),
        .min_i       (min_v),
        .max_i       (max_v),
        .clear_i     (clear),
        .valid_i     (valid_in),
        .ready_o     (ready_out),
        .valid_o     (valid_out),
        .ready_i     (ready_in),
        .busy_o      (busy),
        .stall_cnt_o (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 32'h8020_0003;
        return y;
    endfunction

    function automatic logic [31:0] seed_of(input int c);
        logic [31:0] s;
        s = SEED ^ 32'(c);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic int draw_n(input logic [31:0] lf);
        int unsigned lo, hi;
        lo = (min_v < max_v) ? 32'(min_v) : 32'(max_v);
        hi = (min_v < max_v) ? 32'(max_v) : 32'(min_v);
        case (mode)
            2'd0:    return 0;
            2'd1:    return int'(min_v);
            default: return int'(lo + (lf % (hi - lo + 1)));
        endcase
    endfunction

    task automatic model_pre();
        int n;
        for (int c = 0; c < NCH; c++) begin
            if (!rst_n) begin
                m_active[c] = 0; m_open[c] = 0; m_wait[c] = 0; m_hs[c] = 0;
                m_stall[c]  = 0; m_lfsr[c] = seed_of(c);
                exp_v[c] = 1'b0; exp_r[c] = 1'b0; exp_b[c] = 1'b0;
            end else begin
                exp_b[c] = m_active[c];
                if (!m_active[c] && valid_in[c]) begin
                    n = draw_n(m_lfsr[c]);
                    if (c == 0) m_draws.push_back(n);
                    m_lfsr[c]   = lfsr_step(m_lfsr[c]);
                    m_active[c] = 1;
                    m_wait[c]   = n;
                    m_hs[c]     = (mode == 2'd3) ? BL : 1;
                end
                m_open[c] = m_active[c] && (m_wait[c] == 0);
                exp_v[c]  = valid_in[c] && m_open[c];
                exp_r[c]  = ready_in[c] && m_open[c];
            end
            exp_s[c*SW +: SW] = SW'(m_stall[c]);
        end
    endtask

    task automatic model_post();
        if (rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                if (clear) m_stall[c] = 0;
                else if (valid_in[c] && !m_open[c] && m_stall[c] < (1 << SW) - 1) m_stall[c]++;
                if (m_active[c]) begin
                    if (m_open[c]) begin
                        if (valid_in[c] && ready_in[c]) begin
                            m_hs[c]--;
                            if (m_hs[c] == 0) m_active[c] = 0;
                        end
                    end else begin
                        m_wait[c]--;
                    end
                end
            end
        end
    endtask

    // Inputs are set at posedge+1 by the caller; outputs sampled at negedge.
    task automatic drive_cycle();
        @(negedge clk);
        model_pre();
        obs_v = valid_out; obs_r = ready_out; obs_b = busy; obs_s = stall;
        model_post();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; valid_in = '0; ready_in = '0; clear = 1'b0;
        drive_cycle();
        drive_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 2'd0; min_v = 8'd0; max_v = 8'd0; clear = 1'b0;
        valid_in = '1; ready_in = '1;
        for (int k = 0; k < 3; k++) begin
            drive_cycle();
            checks++;
            if ({obs_v, obs_r, obs_b, obs_s} !== '0) begin
                errors++;
                $display("FAIL reset_outputs k=%0d got v=%b r=%b b=%b s=%h want all zero", k, obs_v, obs_r, obs_b, obs_s);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        apply_reset();
        mode = 2'd0; valid_in = 2'b01; ready_in = 2'b01;
        for (int k = 0; k < 20; k++) begin
            drive_cycle();
            checks++;
            if (obs_v[0] !== 1'b1 || obs_b[0] !== 1'b0 || obs_s !== '0) begin
                errors++;
                $display("FAIL bypass_pass k=%0d got v=%b b=%b s=%h want v=1 b=0 s=0", k, obs_v[0], obs_b[0], obs_s);
            end
            checks++;
            if ({obs_v, obs_r, obs_b, obs_s} !== {exp_v, exp_r, exp_b, exp_s}) begin
                errors++;
                $display("FAIL bypass_model k=%0d got v=%b r=%b b=%b s=%h want v=%b r=%b b=%b s=%h", k, obs_v, obs_r, obs_b, obs_s, exp_v, exp_r, exp_b, exp_s);
            end
        end
    endtask

    task automatic test_fixed();
        logic want_v, want_b;
        apply_reset();
        clear = 1'b1; mode = 2'd1; min_v = 8'd3; max_v = 8'd3; valid_in = '0; ready_in = 2'b01;
        drive_cycle();
        clear = 1'b0; valid_in = 2'b01;
        for (int k = 0; k < 5; k++) begin
            drive_cycle();
            want_v = (k == 3);
            want_b = (k >= 1 && k <= 3);
            checks++;
            if (obs_v[0] !== want_v || obs_b[0] !== want_b) begin
                errors++;
                $display("FAIL fixed_timing t+%0d got v=%b b=%b want v=%b b=%b", k, obs_v[0], obs_b[0], want_v, want_b);
            end
            checks++;
            if ({obs_v, obs_r, obs_b, obs_s} !== {exp_v, exp_r, exp_b, exp_s}) begin
                errors++;
                $display("FAIL fixed_model t+%0d got v=%b r=%b b=%b s=%h want v=%b r=%b b=%b s=%h", k, obs_v, obs_r, obs_b, obs_s, exp_v, exp_r, exp_b, exp_s);
            end
            if (k == 4) begin
                checks++;
                if (obs_s[3:0] !== 4'd3) begin
                    errors++;
                    $display("FAIL fixed_stall got %0d want 3", obs_s[3:0]);
                end
            end
        end
    endtask

    task automatic collect_uniform(input logic [7:0] mn, input logic [7:0] mx);
        int closed;
        closed = 0;
        apply_reset();
        mode = 2'd2; min_v = mn; max_v = mx; valid_in = 2'b01; ready_in = 2'b01;
        obs_d.delete();
        m_draws.delete();
        for (int k = 0; k < 20000 && obs_d.size() < 1000; k++) begin
            drive_cycle();
            if (obs_v[0]) begin
                obs_d.push_back(closed);
                closed = 0;
            end else begin
                closed++;
            end
        end
    endtask

    task automatic test_uniform();
        int hist[8];
        int bad_model, bad_range, bad_rerun;
        foreach (hist[i]) hist[i] = 0;
        bad_model = 0; bad_range = 0; bad_rerun = 0;
        collect_uniform(8'd2, 8'd5);
        checks++;
        if (obs_d.size() != 1000) begin
            errors++;
            $display("FAIL uniform_count got %0d transactions want 1000", obs_d.size());
        end
        foreach (obs_d[i]) begin
            if (i >= m_draws.size() || obs_d[i] != m_draws[i]) bad_model++;
            if (obs_d[i] < 2 || obs_d[i] > 5) bad_range++;
            else hist[obs_d[i]]++;
        end
        checks++;
        if (bad_model != 0) begin
            errors++;
            $display("FAIL uniform_model got %0d delay mismatches want 0", bad_model);
        end
        checks++;
        if (bad_range != 0) begin
            errors++;
            $display("FAIL uniform_range got %0d delays outside [2,5] want 0", bad_range);
        end
        for (int v = 2; v <= 5; v++) begin
            checks++;
            if (hist[v] == 0) begin
                errors++;
                $display("FAIL uniform_hit delay=%0d got 0 occurrences want >0", v);
            end
        end
        run_a = obs_d;
        collect_uniform(8'd5, 8'd2);
        foreach (run_a[i]) begin
            if (i >= obs_d.size() || obs_d[i] != run_a[i]) bad_rerun++;
        end
        checks++;
        if (bad_rerun != 0 || obs_d.size() != run_a.size()) begin
            errors++;
            $display("FAIL uniform_rerun got %0d differing delays (len %0d) want 0 (len %0d)", bad_rerun, obs_d.size(), run_a.size());
        end
    endtask

    task automatic test_burst();
        logic pv;
        apply_reset();
        mode = 2'd3; min_v = 8'd2; max_v = 8'd2; valid_in = 2'b01;
        for (int k = 0; k < 36; k++) begin
            ready_in = (k >= 27 && k <= 29) ? 2'b00 : 2'b01;
            drive_cycle();
            if (k < 27)      pv = ((k % 6) >= 2);
            else if (k < 33) pv = 1'b1;
            else             pv = (k >= 35);
            checks++;
            if (obs_v[0] !== pv) begin
                errors++;
                $display("FAIL burst_pattern k=%0d got v=%b want %b", k, obs_v[0], pv);
            end
            checks++;
            if ({obs_v, obs_r, obs_b, obs_s} !== {exp_v, exp_r, exp_b, exp_s}) begin
                errors++;
                $display("FAIL burst_model k=%0d got v=%b r=%b b=%b s=%h want v=%b r=%b b=%b s=%h", k, obs_v, obs_r, obs_b, obs_s, exp_v, exp_r, exp_b, exp_s);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        mode = 2'd1; min_v = 8'd10; max_v = 8'd10; valid_in = 2'b01; ready_in = 2'b01;
        for (int k = 0; k < 18; k++) begin
            rst_n = !(k == 5 || k == 6);
            drive_cycle();
            if (k == 5 || k == 6) begin
                checks++;
                if ({obs_v, obs_r, obs_b, obs_s} !== '0) begin
                    errors++;
                    $display("FAIL midreset_zero k=%0d got v=%b r=%b b=%b s=%h want all zero", k, obs_v, obs_r, obs_b, obs_s);
                end
            end else if (k >= 7) begin
                checks++;
                if (obs_v[0] !== (k == 17)) begin
                    errors++;
                    $display("FAIL midreset_rewait k=%0d got v=%b want %b", k, obs_v[0], (k == 17));
                end
            end
            checks++;
            if ({obs_v, obs_r, obs_b, obs_s} !== {exp_v, exp_r, exp_b, exp_s}) begin
                errors++;
                $display("FAIL midreset_model k=%0d got v=%b r=%b b=%b s=%h want v=%b r=%b b=%b s=%h", k, obs_v, obs_r, obs_b, obs_s, exp_v, exp_r, exp_b, exp_s);
            end
            if (k == 17) begin
                checks++;
                if (obs_s[3:0] !== 4'd10) begin
                    errors++;
                    $display("FAIL midreset_stall got %0d want 10", obs_s[3:0]);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_multi_channel();
        apply_reset();
        mode = 2'd2; min_v = 8'd1; max_v = 8'd6;
        for (int k = 0; k < 400; k++) begin
            valid_in[0] = 1'($urandom_range(0, 1));
            valid_in[1] = 1'b1;
            ready_in    = 2'($urandom_range(0, 3));
            drive_cycle();
            checks++;
            if ({obs_v, obs_r, obs_b, obs_s} !== {exp_v, exp_r, exp_b, exp_s}) begin
                errors++;
                $display("FAIL multi_model k=%0d got v=%b r=%b b=%b s=%h want v=%b r=%b b=%b s=%h", k, obs_v, obs_r, obs_b, obs_s, exp_v, exp_r, exp_b, exp_s);
            end
        end
        checks++;
        if (obs_s[7:4] !== 4'hF) begin
            errors++;
            $display("FAIL multi_saturate got %0d want 15", obs_s[7:4]);
        end
    endtask

    task automatic test_clear();
        apply_reset();
        mode = 2'd1; min_v = 8'd20; max_v = 8'd20; valid_in = 2'b10; ready_in = 2'b11;
        for (int k = 0; k < 21; k++) begin
            clear = (k == 18);
            drive_cycle();
            checks++;
            if ({obs_v, obs_r, obs_b, obs_s} !== {exp_v, exp_r, exp_b, exp_s}) begin
                errors++;
                $display("FAIL clear_model k=%0d got v=%b r=%b b=%b s=%h want v=%b r=%b b=%b s=%h", k, obs_v, obs_r, obs_b, obs_s, exp_v, exp_r, exp_b, exp_s);
            end
            if (k == 18) begin
                checks++;
                if (obs_s !== 8'hF0) begin
                    errors++;
                    $display("FAIL clear_saturated got %h want f0", obs_s);
                end
            end
            if (k == 19) begin
                checks++;
                if (obs_s !== 8'h00) begin
                    errors++;
                    $display("FAIL clear_wins got %h want 00", obs_s);
                end
            end
            if (k == 20) begin
                checks++;
                if (obs_s !== 8'h10) begin
                    errors++;
                    $display("FAIL clear_recount got %h want 10", obs_s);
                end
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; clear = 1'b0; mode = 2'd0; min_v = 8'd0; max_v = 8'd0;
        valid_in = '0; ready_in = '0;
        test_reset();
        test_bypass();
        test_fixed();
        test_uniform();
        test_burst();
        test_reset_mid_wait();
        test_multi_channel();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rand_stall_gate.md
# rand_stall_gate

Multi-channel, synthesizable handshake throttle for constrained-random verification benches. Each channel sits between an upstream valid/ready source and a downstream sink and holds the handshake closed for a configurable number of cycles after each new transaction appears. The delay can be zero, fixed, uniformly random in [min, max], or burst-gated. It replaces ad-hoc random-wait loops in drivers with a reproducible, seedable, parametrised gate that can also be used inside DUT wrappers.

## Interface
- `NumChannels`, 1: number of independent gated channels.
- `CntWidth`, 8: width of min/max delay and wait counter.
- `StatWidth`, 16: width of per-channel stall statistic counter.
- `BurstLen`, 4: handshakes allowed per open window in BURST mode; must be ≥1.
- `LfsrSeed`, 32'hACE1_2468: base seed; channel c uses `LfsrSeed ^ c`, and an all-zero result is replaced by 32'h1.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous reset, active-low.
- `mode_i` in 2: 0 BYPASS, 1 FIXED, 2 UNIFORM, 3 BURST.
- `min_i` in CntWidth: minimum delay N.
- `max_i` in CntWidth: maximum delay N.
- `clear_i` in 1: synchronous clear of all `stall_cnt_o`.
- `valid_i` in NumChannels: upstream valid, one bit per channel.
- `ready_o` out NumChannels: `ready_i[c] & open[c]`.
- `valid_o` out NumChannels: `valid_i[c] & open[c]`.
- `ready_i` in NumChannels: downstream ready.
- `busy_o` out NumChannels: channel state ≠ IDLE.
- `stall_cnt_o` out NumChannels×StatWidth: saturating count of cycles with `valid_i[c]` high and `open[c]` low.

## Operation
- Per-channel FSM with states IDLE, WAIT, and OPEN.
- In IDLE, when `valid_i` is high, a delay N is drawn, the LFSR advances one step, and `mode_i` is sampled.
- Modes are sampled only at the draw. A mode change mid-WAIT or mid-OPEN takes effect at the next draw.
- Delay N by mode:
  - BYPASS: 0.
  - FIXED: `min_i`.
  - UNIFORM and BURST: `lo + (lfsr % (hi-lo+1))`, where lo=min(min_i,max_i) and hi=max(min_i,max_i).
  - The span is computed in CntWidth+1 bits, so 0..2^CntWidth−1 does not overflow.
- IDLE transitions on a draw:
  - N=0: `open` is high combinationally in the same cycle. If the handshake completes that cycle, stay in IDLE (BURST: go to OPEN with burst count 1 unless BurstLen=1). Otherwise go to OPEN.
  - N=1: go to OPEN.
  - N≥2: go to WAIT with cnt=N−1.
- WAIT: cnt decrements each cycle. When cnt=1, the next state is OPEN. `open` is low throughout WAIT.
- OPEN: `open` is high. Each handshake (`valid_i & ready_i`) increments the burst count. The channel returns to IDLE after 1 handshake, or after BurstLen handshakes in BURST mode.
- `valid_i` dropping in WAIT or OPEN (upstream protocol violation) does not abort the FSM.
- LFSR: 32-bit Galois, taps 0x8020_0003. It advances only on a draw.
- `stall_cnt_o` saturates at all-ones. `clear_i` wins over an increment in the same cycle.

## Timing
- Reset values: state IDLE, cnt 0, burst count 0, LFSR = seed, `stall_cnt_o`=0, `busy_o`=0, `valid_o`=`ready_o`=0.
- Reset asserted mid-WAIT or mid-OPEN aborts immediately. The LFSR is reseeded.
- If `valid_i` first rises at cycle t with draw N, `valid_o` is low for cycles t..t+N−1 and first high at t+N.
- The output path is combinational from `valid_i`/`ready_i` to `valid_o`/`ready_o`. No added latency when open.
- Back-to-back: the cycle after the closing handshake is IDLE, and a new draw occurs if `valid_i` is high.

## Structure
- Package `rand_stall_pkg`:
  - `mode_e`, `state_e`.
  - Default LFSR taps constant.
  - Function `lfsr_next`.
- Sub-module `rand_stall_chan`: one channel (FSM, LFSR, counters). The top generates NumChannels instances and ties the shared mode/min/max/clear inputs to each.

## Test plan
- BYPASS, `valid_i`=1, `ready_i`=1 → `valid_o` high in the same cycle, `stall_cnt_o`=0, `busy_o` never high.
- FIXED, min=3, `valid_i` rises at t, `ready_i`=1 → `valid_o` low t..t+2, high at t+3, `stall_cnt_o`=3, IDLE at t+4.
- UNIFORM, min=2, max=5, 1000 transactions → every delay in [2,5], each value hit; min=5/max=2 gives the same range; two runs with the same seed give identical sequences.
- BURST, BurstLen=4, min=max=2, continuous traffic → 2 closed cycles, then 4 handshakes, repeating. With `ready_i` low for 3 cycles in OPEN, the window stays open.
- FIXED, min=10, `rst_ni` pulsed low at WAIT cnt=5 → all outputs 0 during reset; after release, a new full 10-cycle wait occurs.
- NumChannels=2 with different traffic, StatWidth=4 → independent delays per channel; `stall_cnt_o` saturates at 15; `clear_i` coinciding with a stall cycle yields 0.
